// File: rtl/rc4_ksa_engine.sv
// rtl/rc4_ksa_engine.sv - RC4 key-scheduling engine with optional identity fill over a single-port RAM
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 2,
  parameter int INIT_EN   = 1
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             q,
  output logic                   busy,
  output logic                   done,
  output logic                   wren,
  output logic [ADDR_W-1:0]      address,
  output logic [7:0]             data
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_I = '1;
  localparam logic [KW-1:0]     LAST_K = KW'(KEY_BYTES - 1);
  localparam logic [WW-1:0]     LAST_W = WW'(RD_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_RD_I, S_CAP_I, S_RD_J, S_CAP_J, S_WR_I, S_WR_J, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic [KW-1:0]     r_k;
  logic [7:0]        r_si;
  logic [7:0]        r_sj;
  logic [WW-1:0]     r_w;
  logic [ADDR_W-1:0] w_key_low;
  logic [ADDR_W-1:0] w_j_next;
  logic [7:0]        w_i_byte;

  // Only the low ADDR_W bits of the current key byte take part in the j sum.
  assign w_key_low = secret_key[8*(KEY_BYTES-1-int'(r_k)) +: ADDR_W];
  assign w_j_next  = r_j + q[ADDR_W-1:0] + w_key_low;
  assign w_i_byte  = 8'(r_i);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (INIT_EN != 0) ? S_FILL : S_RD_I;
      S_FILL:  if (r_i == LAST_I) w_next = S_RD_I;
      S_RD_I:  if (r_w == LAST_W) w_next = S_CAP_I;
      S_CAP_I: w_next = S_RD_J;
      S_RD_J:  if (r_w == LAST_W) w_next = S_CAP_J;
      S_CAP_J: w_next = S_WR_I;
      S_WR_I:  w_next = S_WR_J;
      S_WR_J:  w_next = (r_i == LAST_I) ? S_DONE : S_RD_I;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // abort outranks start, including a start presented while idle
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_i  <= '0;
      r_j  <= '0;
      r_k  <= '0;
      r_si <= '0;
      r_sj <= '0;
      r_w  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_next != S_IDLE) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
            r_w <= '0;
          end
        end
        S_FILL: r_i <= r_i + 1'b1;
        S_RD_I, S_RD_J: r_w <= (r_w == LAST_W) ? '0 : r_w + 1'b1;
        S_CAP_I: begin
          r_si <= q;
          r_j  <= w_j_next;
        end
        S_CAP_J: r_sj <= q;
        S_WR_J: begin
          if (r_i != LAST_I) begin
            r_i <= r_i + 1'b1;
            r_k <= (r_k == LAST_K) ? '0 : r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    wren    = 1'b0;
    address = '0;
    data    = '0;
    case (r_state)
      S_FILL: begin
        busy    = 1'b1;
        wren    = 1'b1;
        address = r_i;
        data    = w_i_byte;
      end
      S_RD_I, S_CAP_I: begin
        busy    = 1'b1;
        address = r_i;
      end
      S_RD_J, S_CAP_J: begin
        busy    = 1'b1;
        address = r_j;
      end
      S_WR_I: begin
        busy    = 1'b1;
        wren    = 1'b1;
        address = r_i;
        data    = r_sj;
      end
      S_WR_J: begin
        busy    = 1'b1;
        wren    = 1'b1;
        address = r_j;
        data    = r_si;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb/tb_rc4_ksa_engine.sv - scoreboard bench for rc4_ksa_engine across three parameter sets
module tb_rc4_ksa_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic i_reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic preload_c = 1'b0;
  int   sel = 0;

  logic [39:0] key_a = 40'h0102030405;
  logic [23:0] key_b = 24'h000000;
  logic [23:0] key_c = 24'h01abcd;

  logic start_a, start_b, start_c, abort_a, abort_b, abort_c;
  assign start_a = start & (sel == 0);
  assign start_b = start & (sel == 1);
  assign start_c = start & (sel == 2);
  assign abort_a = abort & (sel == 0);
  assign abort_b = abort & (sel == 1);
  assign abort_c = abort & (sel == 2);

  logic busy_a, done_a, wren_a, busy_b, done_b, wren_b, busy_c, done_c, wren_c;
  logic [3:0] addr_a, addr_c;
  logic [7:0] addr_b;
  logic [7:0] data_a, data_b, data_c, q_a, q_b, q_c, pb1, pc1, pc2;
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [256];
  logic [7:0] mem_c [16];

  rc4_ksa_engine #(.ADDR_W(4), .KEY_BYTES(5), .RD_LAT(1), .INIT_EN(1)) dut_a (
    .clock(clock), .i_reset(i_reset), .start(start_a), .abort(abort_a), .secret_key(key_a),
    .q(q_a), .busy(busy_a), .done(done_a), .wren(wren_a), .address(addr_a), .data(data_a));

  rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3), .RD_LAT(2), .INIT_EN(1)) dut_b (
    .clock(clock), .i_reset(i_reset), .start(start_b), .abort(abort_b), .secret_key(key_b),
    .q(q_b), .busy(busy_b), .done(done_b), .wren(wren_b), .address(addr_b), .data(data_b));

  rc4_ksa_engine #(.ADDR_W(4), .KEY_BYTES(3), .RD_LAT(3), .INIT_EN(0)) dut_c (
    .clock(clock), .i_reset(i_reset), .start(start_c), .abort(abort_c), .secret_key(key_c),
    .q(q_c), .busy(busy_c), .done(done_c), .wren(wren_c), .address(addr_c), .data(data_c));

  // Behavioural RAMs whose read pipeline depth matches each instance's RD_LAT.
  always @(posedge clock) begin
    if (wren_a) mem_a[addr_a] <= data_a;
    q_a <= mem_a[addr_a];
  end

  always @(posedge clock) begin
    if (wren_b) mem_b[addr_b] <= data_b;
    pb1 <= mem_b[addr_b];
    q_b <= pb1;
  end

  always @(posedge clock) begin
    if (preload_c) begin
      for (int n = 0; n < 16; n++) mem_c[n] <= 8'(15 - n);
    end else if (wren_c) begin
      mem_c[addr_c] <= data_c;
    end
    pc1 <= mem_c[addr_c];
    pc2 <= pc1;
    q_c <= pc2;
  end

  logic cur_busy, cur_done, cur_wren;
  int   cur_addr, cur_data;
  always_comb begin
    cur_busy = 1'b0; cur_done = 1'b0; cur_wren = 1'b0; cur_addr = 0; cur_data = 0;
    case (sel)
      0: begin cur_busy = busy_a; cur_done = done_a; cur_wren = wren_a; cur_addr = int'(addr_a); cur_data = int'(data_a); end
      1: begin cur_busy = busy_b; cur_done = done_b; cur_wren = wren_b; cur_addr = int'(addr_b); cur_data = int'(data_b); end
      default: begin cur_busy = busy_c; cur_done = done_c; cur_wren = wren_c; cur_addr = int'(addr_c); cur_data = int'(data_c); end
    endcase
  end

  int n_checks = 0;
  int n_pass = 0;
  int s_m [256];
  int exp_q [$];

  // Software KSA: pushes every expected RAM write (addr*256+data) and leaves the final table in s_m.
  task automatic model(input int d, input int kb, input logic [255:0] key, input bit init);
    int j, si, sj, kbyte;
    if (init) begin
      for (int i = 0; i < d; i++) begin
        s_m[i] = i;
        exp_q.push_back(i * 256 + i);
      end
    end
    j = 0;
    for (int i = 0; i < d; i++) begin
      kbyte = int'(key[8*(kb-1-(i%kb)) +: 8]);
      j = (j + s_m[i] + kbyte) % d;
      si = s_m[i];
      sj = s_m[j];
      exp_q.push_back(i * 256 + sj);
      exp_q.push_back(j * 256 + si);
      s_m[i] = sj;
      s_m[j] = si;
    end
  endtask

  task automatic kick();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
  endtask

  // Steps the selected DUT from the first cycle after acceptance until done, popping the scoreboard per write.
  task automatic run_collect(input int budget, input int poke_at, input int hold,
                             output int done_at, output int writes, output int bad,
                             output int busy_bad, output int w0, output int w1);
    int e, obs;
    done_at = 0; writes = 0; bad = 0; busy_bad = 0; w0 = -1; w1 = -1;
    for (int n = 1; n <= budget; n++) begin
      start = (n == poke_at) || (n <= hold);
      if (cur_wren) begin
        obs = cur_addr * 256 + cur_data;
        if (writes == 0) w0 = obs;
        else if (writes == 1) w1 = obs;
        writes++;
        if (exp_q.size() == 0) bad++;
        else begin
          e = exp_q.pop_front();
          if (e != obs) bad++;
        end
      end
      if (cur_done) begin
        done_at = n;
        if (cur_busy) busy_bad++;
        break;
      end
      if (!cur_busy) busy_bad++;
      @(negedge clock);
    end
  endtask

  function automatic int tbl_bad(input int d);
    int b;
    logic [7:0] v;
    b = 0;
    for (int n = 0; n < d; n++) begin
      case (sel)
        0: v = mem_a[n[3:0]];
        1: v = mem_b[n[7:0]];
        default: v = mem_c[n[3:0]];
      endcase
      if (v !== 8'(s_m[n])) b++;
    end
    return b;
  endfunction

  int done_at, writes, bad, busy_bad, w0, w1;

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy_a, done_a, wren_a, addr_a, data_a} !== 15'd0) $display("FAIL reset_a got %h want 0", {busy_a, done_a, wren_a, addr_a, data_a});
    else n_pass++;
    n_checks++;
    if ({busy_b, done_b, wren_b, addr_b, data_b} !== 19'd0) $display("FAIL reset_b got %h want 0", {busy_b, done_b, wren_b, addr_b, data_b});
    else n_pass++;
    n_checks++;
    if ({busy_c, done_c, wren_c, addr_c, data_c} !== 15'd0) $display("FAIL reset_c got %h want 0", {busy_c, done_c, wren_c, addr_c, data_c});
    else n_pass++;
    i_reset = 1'b0;
  endtask

  task automatic test_full_table();
    sel = 1;
    model(256, 3, {232'd0, key_b}, 1'b1);
    kick();
    run_collect(4000, 0, 0, done_at, writes, bad, busy_bad, w0, w1);
    n_checks++;
    if (done_at !== 2305) $display("FAIL full_done_cycle got %0d want 2305", done_at); else n_pass++;
    n_checks++;
    if (writes !== 768) $display("FAIL full_write_count got %0d want 768", writes); else n_pass++;
    n_checks++;
    if (bad !== 0 || exp_q.size() !== 0) $display("FAIL full_write_seq got %0d bad %0d left want 0 0", bad, exp_q.size()); else n_pass++;
    n_checks++;
    if (busy_bad !== 0) $display("FAIL full_busy got %0d bad cycles want 0", busy_bad); else n_pass++;
    @(negedge clock);
    n_checks++;
    if (tbl_bad(256) !== 0) $display("FAIL full_table got %0d wrong entries want 0", tbl_bad(256)); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_key5();
    int seen [16];
    int perm_bad;
    sel = 0;
    model(16, 5, {216'd0, key_a}, 1'b1);
    kick();
    run_collect(500, 0, 0, done_at, writes, bad, busy_bad, w0, w1);
    n_checks++;
    if (done_at !== 113) $display("FAIL key5_done_cycle got %0d want 113", done_at); else n_pass++;
    n_checks++;
    if (writes !== 48 || bad !== 0) $display("FAIL key5_writes got %0d writes %0d bad want 48 0", writes, bad); else n_pass++;
    @(negedge clock);
    n_checks++;
    if (tbl_bad(16) !== 0) $display("FAIL key5_table got %0d wrong entries want 0", tbl_bad(16)); else n_pass++;
    perm_bad = 0;
    for (int n = 0; n < 16; n++) seen[n] = 0;
    for (int n = 0; n < 16; n++) begin
      if (mem_a[n] < 8'd16) seen[mem_a[n][3:0]]++;
    end
    for (int n = 0; n < 16; n++) if (seen[n] != 1) perm_bad++;
    n_checks++;
    if (perm_bad !== 0) $display("FAIL key5_permutation got %0d bad values want 0", perm_bad); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_no_init();
    sel = 2;
    @(negedge clock);
    preload_c = 1'b1;
    @(negedge clock);
    preload_c = 1'b0;
    for (int n = 0; n < 16; n++) s_m[n] = 15 - n;
    model(16, 3, {232'd0, key_c}, 1'b0);
    kick();
    run_collect(500, 0, 0, done_at, writes, bad, busy_bad, w0, w1);
    n_checks++;
    if (done_at !== 161) $display("FAIL noinit_done_cycle got %0d want 161", done_at); else n_pass++;
    n_checks++;
    if (writes !== 32 || bad !== 0) $display("FAIL noinit_writes got %0d writes %0d bad want 32 0", writes, bad); else n_pass++;
    n_checks++;
    if (w0 !== 15 || w1 !== 15) $display("FAIL noinit_same_addr got %0h %0h want f f", w0, w1); else n_pass++;
    @(negedge clock);
    n_checks++;
    if (tbl_bad(16) !== 0) $display("FAIL noinit_table got %0d wrong entries want 0", tbl_bad(16)); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    sel = 0;
    model(16, 5, {216'd0, key_a}, 1'b1);
    kick();
    run_collect(500, 40, 0, done_at, writes, bad, busy_bad, w0, w1);
    n_checks++;
    if (done_at !== 113 || bad !== 0) $display("FAIL b2b_first_run got done %0d bad %0d want 113 0", done_at, bad); else n_pass++;
    model(16, 5, {216'd0, key_a}, 1'b1);
    start = 1'b1;
    @(negedge clock);
    n_checks++;
    if (cur_busy !== 1'b0 || cur_done !== 1'b0) $display("FAIL b2b_idle_gap got busy %b done %b want 0 0", cur_busy, cur_done); else n_pass++;
    @(negedge clock);
    run_collect(500, 0, 1, done_at, writes, bad, busy_bad, w0, w1);
    n_checks++;
    if (done_at !== 113 || bad !== 0 || exp_q.size() !== 0) $display("FAIL b2b_second_run got done %0d bad %0d want 113 0", done_at, bad); else n_pass++;
    start = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (cur_busy !== 1'b0) $display("FAIL b2b_single_restart got busy %b want 0", cur_busy); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_abort();
    int done_seen;
    sel = 0;
    kick();
    start = 1'b0;
    repeat (20) @(negedge clock);
    n_checks++;
    if ({cur_wren, cur_addr, cur_data} !== {1'b1, 32'd0, 32'd1}) $display("FAIL abort_in_wr_i got wren %b addr %0d data %0d want 1 0 1", cur_wren, cur_addr, cur_data); else n_pass++;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_checks++;
    if (cur_wren !== 1'b0 || cur_busy !== 1'b0) $display("FAIL abort_next got wren %b busy %b want 0 0", cur_wren, cur_busy); else n_pass++;
    done_seen = 0;
    repeat (150) begin
      if (cur_done) done_seen++;
      @(negedge clock);
    end
    n_checks++;
    if (done_seen !== 0) $display("FAIL abort_no_done got %0d pulses want 0", done_seen); else n_pass++;
    model(16, 5, {216'd0, key_a}, 1'b1);
    kick();
    run_collect(500, 0, 0, done_at, writes, bad, busy_bad, w0, w1);
    @(negedge clock);
    n_checks++;
    if (done_at !== 113 || bad !== 0 || tbl_bad(16) !== 0) $display("FAIL abort_rerun got done %0d bad %0d tbl %0d want 113 0 0", done_at, bad, tbl_bad(16)); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset_priority();
    sel = 0;
    kick();
    start = 1'b0;
    repeat (18) @(negedge clock);
    n_checks++;
    if ({cur_busy, cur_wren, cur_addr} !== {1'b1, 1'b0, 32'd1}) $display("FAIL rst_in_rd_j got busy %b wren %b addr %0d want 1 0 1", cur_busy, cur_wren, cur_addr); else n_pass++;
    i_reset = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({busy_a, done_a, wren_a, addr_a, data_a} !== 15'd0) $display("FAIL rst_outputs got %h want 0", {busy_a, done_a, wren_a, addr_a, data_a}); else n_pass++;
    i_reset = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    @(negedge clock);
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL rst_start_ignored got busy %b want 0", busy_a); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_table();
    test_key5();
    test_no_init();
    test_back_to_back();
    test_abort();
    test_reset_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
# rc4_ksa_engine

Parametrised RC4 key-scheduling engine that optionally fills a single-port byte RAM with the identity permutation and then scrambles it using a secret key of configurable length. It sits between the top-level control FSM and the `s` RAM, in the same place as the fixed 3-byte/256-entry scrambler. It generalises that scrambler in table depth, key length and RAM read latency. It adds an integrated identity fill, a busy/done handshake and an abort input.

## Interface
- `ADDR_W`, 8: table depth D = 2^ADDR_W; legal range 4..8.
- `KEY_BYTES`, 3: secret key length in bytes; legal range 1..32.
- `RD_LAT`, 2: RAM read latency in cycles; legal range 1..3.
- `INIT_EN`, 1: 1 = run the identity fill s[i]=i before scrambling; 0 = scramble existing contents.
- `clock`  in  1  clock; all logic on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `abort`  in  1  cancels a run in progress; returns to IDLE without `done`.
- `secret_key`  in  8*KEY_BYTES  key; byte 0 = bits [8*KEY_BYTES-1 -: 8]; must be held stable while busy.
- `q`  in  8  RAM read data.
- `busy`  out  1  high from the cycle after `start` is accepted until the DONE cycle (exclusive).
- `done`  out  1  one-cycle pulse when the run completes.
- `wren`  out  1  RAM write enable.
- `address`  out  ADDR_W  RAM address.
- `data`  out  8  RAM write data.

## Operation
- Registers: `i` and `j` (ADDR_W bits each), `k` (key byte index, 0..KEY_BYTES-1, wraps), `si` and `sj` (8 bits each), wait counter `w` (0..RD_LAT-1).
- The engine runs `j = (j + s[i] + key[k]) mod D; swap(s[i], s[j])` for i = 0..D-1. `k` increments with `i` and wraps to 0 after KEY_BYTES-1; no modulo hardware.
- All sums are truncated to ADDR_W bits; the upper 8-ADDR_W bits of `q` and of the key byte are dropped.
- States:
  - IDLE: `busy`=0, `wren`=0. On `start`: clear `i`, `j`, `k`; go to FILL if INIT_EN=1, else RD_I.
  - FILL: `wren`=1, `address`=i, `data`={0,i}; `i`++. When i=D-1, clear `i` and go to RD_I.
  - RD_I: `address`=i for RD_LAT cycles (count with `w`), then go to CAP_I.
  - CAP_I: `address`=i; `si`<=q; `j`<=j+q+key[k]; go to RD_J.
  - RD_J: `address`=j for RD_LAT cycles, then go to CAP_J.
  - CAP_J: `address`=j; `sj`<=q; go to WR_I.
  - WR_I: `wren`=1, `address`=i, `data`=sj; go to WR_J.
  - WR_J: `wren`=1, `address`=j, `data`=si. If i=D-1 go to DONE; else `i`++, advance `k`, go to RD_I.
  - DONE: `done`=1, `busy`=0; go to IDLE.
- i==j: both writes carry the same value, so the table is unchanged; no special-casing.
- `start` while busy: ignored. `start` in the DONE cycle: ignored.
- `abort` (any non-IDLE state): next state is IDLE, `wren`=0 from the next cycle, no `done`. RAM contents are left partially scrambled.
- `i_reset` takes priority over `abort`, and `abort` over `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `wren`=0, `address`=0, `data`=0; state = IDLE; all internal registers = 0.
- Outputs are decoded from registered state only; no combinational path from `q`, `start` or `abort` to any output.
- Start accepted at edge t. FILL occupies cycles t+1..t+D.
- Each scramble iteration takes 2*RD_LAT+4 cycles.
- `done` is high in cycle t + F + D*(2*RD_LAT+4) + 1, where F = D if INIT_EN=1, else 0.
  - ADDR_W=8, RD_LAT=2, INIT_EN=1: 2305 cycles.
  - ADDR_W=4, RD_LAT=1, INIT_EN=1: 113 cycles.
- `address` is held constant through each RD state and the following CAP state.
- A new `start` is accepted in the cycle immediately after `done` (back-to-back runs).

## Test plan
- ADDR_W=8, KEY_BYTES=3, RD_LAT=2, INIT_EN=1, key 0x000000, behavioural RAM model -> `done` in cycle 2305; final RAM matches the software KSA; exactly 256 FILL writes plus 512 swap writes observed.
- ADDR_W=4, KEY_BYTES=5, RD_LAT=1, key 0x0102030405 -> `done` in cycle 113; final table is a permutation of 0..15 matching the model; key bytes used in order 01,02,03,04,05,01,…
- INIT_EN=0, RAM preloaded with s[n]=15-n (ADDR_W=4), any key that yields j==i at i=0 -> writes to the same address carry equal data; final table matches the model.
- `start` pulsed again mid-run, then for 3 cycles back-to-back after `done` -> mid-run pulse ignored; exactly one new run begins, in the cycle after `done`.
- `abort` asserted in a WR_I cycle -> `wren`=0 and `busy`=0 next cycle; `done` never pulses; a later `start` completes normally with the correct result.
- `i_reset` asserted in RD_J with `abort`=1 and `start`=1 -> all outputs 0 next cycle; state IDLE; the simultaneous `start` is not accepted.
